// File: rtl/mem_access.sv
// mem_access: memory-access stage between execute and register write-back.
//
// Takes the execute record (ALU result, effective address, store operand,
// destination register), performs loads and stores over a req/ack data-memory
// port, formats load data and emits one registered write-back record per
// instruction. Any memory operation stalls upstream until the ack arrives.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a BUSY access after
// TIMEOUT_CYCLES cycles without mem_ack_i (reported on err_o). Without the
// macro there is no counter, BUSY waits indefinitely and err_o is tied to 0.
//
// Ports:
//   clk, rst                 stage clock, synchronous active-high reset
//   valid_i                  execute record present
//   MemRead_i / MemWrite_i   load / store (mutually exclusive)
//   MemFunct3_i              access size / signedness (instr[14:12])
//   MemAddr_i                effective address
//   StoreData_i              store operand
//   WriteData_i              ALU/link result for non-memory instructions
//   WriteDataNum_i           destination register index
//   WriteReg_i               instruction writes a register
//   stall_o                  upstream must hold (high while BUSY)
//   mem_req_o .. mem_be_o    data-memory request (held constant while BUSY)
//   mem_rdata_i, mem_ack_i   data-memory response
//   wb_*_o                   one-cycle write-back record
//   misalign_o, err_o        record flags: misaligned access / timeout

module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  MemFunct3_i,
    input  logic [31:0] MemAddr_i,
    input  logic [31:0] StoreData_i,
    input  logic [31:0] WriteData_i,
    input  logic [4:0]  WriteDataNum_i,
    input  logic        WriteReg_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        wb_valid_o,
    output logic        wb_WriteReg_o,
    output logic [4:0]  wb_WriteDataNum_o,
    output logic [31:0] wb_WriteData_o,
    output logic        misalign_o,
    output logic        err_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_access: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [0:0] {StIdle, StBusy} state_t;

    state_t      state;

    // Access context latched at acceptance, used when the ack returns.
    logic [1:0]  lat_lane;
    logic [2:0]  lat_funct3;
    logic [4:0]  lat_rd;
    logic        lat_wr;
    logic        lat_load;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  tmo_cnt;
`endif

    logic        is_mem;
    logic        access_ok;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic        rd_nonzero;

    assign is_mem     = MemRead_i | MemWrite_i;
    assign rd_nonzero = (WriteDataNum_i != 5'd0);
    assign stall_o    = (state == StBusy);

    // Legality: undefined funct3 encodings are reported as misaligned.
    always_comb begin
        access_ok = 1'b0;
        case (MemFunct3_i)
            3'b000:  access_ok = 1'b1;
            3'b001:  access_ok = ~MemAddr_i[0];
            3'b010:  access_ok = (MemAddr_i[1:0] == 2'b00);
            3'b100:  access_ok = MemRead_i;
            3'b101:  access_ok = MemRead_i & ~MemAddr_i[0];
            default: access_ok = 1'b0;
        endcase
    end

    // Byte enables and lane-replicated store data; loads use the same enables.
    always_comb begin
        req_be    = 4'b1111;
        req_wdata = StoreData_i;
        case (MemFunct3_i[1:0])
            2'b00: begin
                req_be    = 4'b0001 << MemAddr_i[1:0];
                req_wdata = {4{StoreData_i[7:0]}};
            end
            2'b01: begin
                req_be    = 4'b0011 << MemAddr_i[1:0];
                req_wdata = {2{StoreData_i[15:0]}};
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = StoreData_i;
            end
        endcase
    end

    // Load lane selection and extension from the latched address lane.
    always_comb begin
        rd_byte   = mem_rdata_i[{lat_lane, 3'b000} +: 8];
        rd_half   = mem_rdata_i[{lat_lane[1], 4'b0000} +: 16];
        load_data = mem_rdata_i;
        case (lat_funct3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_data = {24'd0, rd_byte};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= StIdle;
            lat_lane          <= 2'd0;
            lat_funct3        <= 3'd0;
            lat_rd            <= 5'd0;
            lat_wr            <= 1'b0;
            lat_load          <= 1'b0;
            mem_req_o         <= 1'b0;
            mem_we_o          <= 1'b0;
            mem_addr_o        <= 32'd0;
            mem_wdata_o       <= 32'd0;
            mem_be_o          <= 4'd0;
            wb_valid_o        <= 1'b0;
            wb_WriteReg_o     <= 1'b0;
            wb_WriteDataNum_o <= 5'd0;
            wb_WriteData_o    <= 32'd0;
            misalign_o        <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            err_o             <= 1'b0;
            tmo_cnt           <= 8'd0;
`endif
        end else begin
            // Record outputs are single-cycle pulses; cleared unless re-set below.
            wb_valid_o        <= 1'b0;
            wb_WriteReg_o     <= 1'b0;
            wb_WriteDataNum_o <= 5'd0;
            wb_WriteData_o    <= 32'd0;
            misalign_o        <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            err_o             <= 1'b0;
`endif
            case (state)
                StIdle: begin
                    if (valid_i) begin
                        if (!is_mem) begin
                            wb_valid_o        <= 1'b1;
                            wb_WriteReg_o     <= WriteReg_i & rd_nonzero;
                            wb_WriteDataNum_o <= WriteDataNum_i;
                            wb_WriteData_o    <= WriteData_i;
                        end else if (!access_ok) begin
                            wb_valid_o        <= 1'b1;
                            misalign_o        <= 1'b1;
                            wb_WriteDataNum_o <= WriteDataNum_i;
                        end else begin
                            lat_lane    <= MemAddr_i[1:0];
                            lat_funct3  <= MemFunct3_i;
                            lat_rd      <= WriteDataNum_i;
                            lat_wr      <= WriteReg_i & rd_nonzero;
                            lat_load    <= MemRead_i;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= MemWrite_i;
                            mem_addr_o  <= {MemAddr_i[31:2], 2'b00};
                            mem_wdata_o <= req_wdata;
                            mem_be_o    <= req_be;
`ifdef MEM_TIMEOUT_EN
                            tmo_cnt     <= 8'd0;
`endif
                            state       <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    // An ack in the timeout cycle takes priority over the abort.
                    if (mem_ack_i) begin
                        mem_req_o         <= 1'b0;
                        wb_valid_o        <= 1'b1;
                        wb_WriteDataNum_o <= lat_rd;
                        if (lat_load) begin
                            wb_WriteReg_o  <= lat_wr;
                            wb_WriteData_o <= load_data;
                        end
                        state <= StIdle;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (tmo_cnt == TimeoutLast) begin
                        mem_req_o         <= 1'b0;
                        wb_valid_o        <= 1'b1;
                        err_o             <= 1'b1;
                        wb_WriteDataNum_o <= lat_rd;
                        state             <= StIdle;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifndef MEM_TIMEOUT_EN
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases for the documented
// scenarios plus randomized instructions checked against a reference model
// computed from access size/offset arithmetic.

module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, MemRead_i, MemWrite_i, WriteReg_i, mem_ack_i;
    logic [2:0]  MemFunct3_i;
    logic [31:0] MemAddr_i, StoreData_i, WriteData_i, mem_rdata_i;
    logic [4:0]  WriteDataNum_i;
    logic        stall_o, mem_req_o, mem_we_o, wb_valid_o, wb_WriteReg_o;
    logic        misalign_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, wb_WriteData_o;
    logic [3:0]  mem_be_o;
    logic [4:0]  wb_WriteDataNum_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYCLES(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .valid_i           (valid_i),
        .MemRead_i         (MemRead_i),
        .MemWrite_i        (MemWrite_i),
        .MemFunct3_i       (MemFunct3_i),
        .MemAddr_i         (MemAddr_i),
        .StoreData_i       (StoreData_i),
        .WriteData_i       (WriteData_i),
        .WriteDataNum_i    (WriteDataNum_i),
        .WriteReg_i        (WriteReg_i),
        .stall_o           (stall_o),
        .mem_req_o         (mem_req_o),
        .mem_we_o          (mem_we_o),
        .mem_addr_o        (mem_addr_o),
        .mem_wdata_o       (mem_wdata_o),
        .mem_be_o          (mem_be_o),
        .mem_rdata_i       (mem_rdata_i),
        .mem_ack_i         (mem_ack_i),
        .wb_valid_o        (wb_valid_o),
        .wb_WriteReg_o     (wb_WriteReg_o),
        .wb_WriteDataNum_o (wb_WriteDataNum_o),
        .wb_WriteData_o    (wb_WriteData_o),
        .misalign_o        (misalign_o),
        .err_o             (err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---- reference model -------------------------------------------------
    function automatic bit ref_legal(bit ld, logic [2:0] f3, logic [31:0] a);
        int size;
        if (f3[1:0] == 2'd3) return 1'b0;
        if (f3[2] && (!ld || f3[1:0] == 2'd2)) return 1'b0;
        size = 1 << f3[1:0];
        return (a % size) == 0;
    endfunction

    function automatic logic [3:0] ref_be(logic [2:0] f3, logic [31:0] a);
        int size, mask;
        size = 1 << f3[1:0];
        mask = ((1 << size) - 1) << (a % 4);
        return 4'(mask & 15);
    endfunction

    function automatic logic [31:0] ref_wdata(logic [2:0] f3, logic [31:0] d);
        if (f3[1:0] == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a, logic [31:0] r);
        longint v, width;
        if (f3[1:0] == 2'd2) return r;
        width = 8 << f3[1:0];
        v = (longint'(r) >> (8 * (a % 4))) & ((64'd1 << width) - 1);
        if (!f3[2] && v >= (64'd1 << (width - 1))) v = v - (64'd1 << width);
        return v[31:0];
    endfunction

    // ---- stimulus ----------------------------------------------------------
    // kind: 0 = non-memory, 1 = load, 2 = store. Called at cycle start
    // (#1 after a rising edge); returns at cycle start after the record pulse.
    task automatic run_op(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] wd,
                          input logic [31:0] rdata, input logic [4:0] rd, input logic wr,
                          input int delay, input bit noisy);
        bit ld, ok;
        logic exp_wr;
        ld = (kind == 1);
        ok = ref_legal(ld, f3, addr);
        check("stall_before", 32'(stall_o), 32'd0);
        valid_i = 1'b1; MemRead_i = ld; MemWrite_i = (kind == 2);
        MemFunct3_i = f3; MemAddr_i = addr; StoreData_i = sd; WriteData_i = wd;
        WriteDataNum_i = rd; WriteReg_i = wr;
        @(posedge clk); #1;
        valid_i = 1'b0; MemAddr_i = $urandom; StoreData_i = $urandom; WriteData_i = $urandom;
        if (kind == 0) begin
            exp_wr = wr && (rd != 5'd0);
            check("alu_wb_valid", 32'(wb_valid_o), 32'd1);
            check("alu_wb_rd", 32'(wb_WriteDataNum_o), 32'(rd));
            check("alu_wb_data", wb_WriteData_o, wd);
            check("alu_wb_we", 32'(wb_WriteReg_o), 32'(exp_wr));
            check("alu_stall", 32'(stall_o), 32'd0);
            check("alu_req", 32'(mem_req_o), 32'd0);
            check("alu_misalign", 32'(misalign_o), 32'd0);
        end else if (!ok) begin
            check("mis_wb_valid", 32'(wb_valid_o), 32'd1);
            check("mis_flag", 32'(misalign_o), 32'd1);
            check("mis_wb_we", 32'(wb_WriteReg_o), 32'd0);
            check("mis_req", 32'(mem_req_o), 32'd0);
            check("mis_stall", 32'(stall_o), 32'd0);
        end else begin
            check("req", 32'(mem_req_o), 32'd1);
            check("we", 32'(mem_we_o), 32'(kind == 2));
            check("addr", mem_addr_o, addr & 32'hFFFF_FFFC);
            check("be", 32'(mem_be_o), 32'(ref_be(f3, addr)));
            if (kind == 2) check("wdata", mem_wdata_o, ref_wdata(f3, sd));
            check("stall_busy", 32'(stall_o), 32'd1);
            check("wb_quiet", 32'(wb_valid_o), 32'd0);
            for (int i = 0; i < delay; i++) begin
                if (noisy) begin
                    valid_i = 1'($urandom); MemRead_i = 1'($urandom); MemWrite_i = 1'b0;
                    MemFunct3_i = 3'($urandom); WriteDataNum_i = 5'($urandom);
                end
                mem_rdata_i = $urandom;
                @(posedge clk); #1;
                check("stall_wait", 32'(stall_o), 32'd1);
                check("req_held", 32'(mem_req_o), 32'd1);
                check("be_held", 32'(mem_be_o), 32'(ref_be(f3, addr)));
                check("addr_held", mem_addr_o, addr & 32'hFFFF_FFFC);
                check("wb_wait", 32'(wb_valid_o), 32'd0);
            end
            valid_i = 1'b0; mem_rdata_i = rdata; mem_ack_i = 1'b1;
            @(posedge clk); #1;
            mem_ack_i = 1'b0; mem_rdata_i = $urandom;
            exp_wr = ld && wr && (rd != 5'd0);
            check("ack_wb_valid", 32'(wb_valid_o), 32'd1);
            check("ack_wb_we", 32'(wb_WriteReg_o), 32'(exp_wr));
            check("ack_wb_rd", 32'(wb_WriteDataNum_o), 32'(rd));
            if (ld) check("ack_wb_data", wb_WriteData_o, ref_load(f3, addr, rdata));
            check("ack_req_low", 32'(mem_req_o), 32'd0);
            check("ack_stall_low", 32'(stall_o), 32'd0);
            check("ack_misalign", 32'(misalign_o), 32'd0);
            check("ack_err", 32'(err_o), 32'd0);
        end
        @(posedge clk); #1;
        check("wb_pulse", 32'(wb_valid_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; WriteReg_i = 1'b0;
        mem_ack_i = 1'b0; MemFunct3_i = 3'd0; MemAddr_i = 32'd0; StoreData_i = 32'd0;
        WriteData_i = 32'd0; mem_rdata_i = 32'd0; WriteDataNum_i = 5'd0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_be", 32'(mem_be_o), 32'd0);
        check("rst_wb_data", wb_WriteData_o, 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ALU pass-through
        run_op(0, 3'd0, 32'd0, 32'd0, 32'h1234_5678, 32'd0, 5'd5, 1'b1, 0, 1'b0);
        // ALU write to x0 is suppressed
        run_op(0, 3'd0, 32'd0, 32'd0, 32'hDEAD_0001, 32'd0, 5'd0, 1'b1, 0, 1'b0);
        // LB sign-extend, upper lane, ack on the third request cycle
        run_op(1, 3'b000, 32'h103, 32'd0, 32'd0, 32'h80FF_FF7F, 5'd7, 1'b1, 2, 1'b0);
        // SH upper lane
        run_op(2, 3'b001, 32'h202, 32'hAAAA_BEEF, 32'd0, 32'd0, 5'd9, 1'b1, 0, 1'b0);
        // LHU and LBU zero-extend
        run_op(1, 3'b101, 32'h402, 32'd0, 32'd0, 32'h9876_5432, 5'd3, 1'b1, 1, 1'b0);
        run_op(1, 3'b100, 32'h401, 32'd0, 32'd0, 32'h0000_F100, 5'd4, 1'b1, 0, 1'b0);
        // Misaligned LW
        run_op(1, 3'b010, 32'h301, 32'd0, 32'd0, 32'd0, 5'd6, 1'b1, 0, 1'b0);

        // Stray ack while idle
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        check("idle_ack_wb", 32'(wb_valid_o), 32'd0);
        check("idle_ack_stall", 32'(stall_o), 32'd0);

        // Reset two cycles into an unacknowledged LW
        valid_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; MemFunct3_i = 3'b010;
        MemAddr_i = 32'h500; WriteDataNum_i = 5'd8; WriteReg_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("rb_req", 32'(mem_req_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rb_req_low", 32'(mem_req_o), 32'd0);
        check("rb_stall_low", 32'(stall_o), 32'd0);
        check("rb_addr_zero", mem_addr_o, 32'd0);
        check("rb_be_zero", 32'(mem_be_o), 32'd0);
        check("rb_wb_valid", 32'(wb_valid_o), 32'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        check("rb_late_ack", 32'(wb_valid_o), 32'd0);
        check("rb_late_stall", 32'(stall_o), 32'd0);

`ifdef MEM_TIMEOUT_EN
        // LW with no ack: abort after 16 BUSY cycles
        valid_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; MemFunct3_i = 3'b010;
        MemAddr_i = 32'h600; WriteDataNum_i = 5'd10; WriteReg_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("tmo_stall", 32'(stall_o), 32'd1);
            check("tmo_no_err", 32'(err_o), 32'd0);
            @(posedge clk); #1;
        end
        check("tmo_err", 32'(err_o), 32'd1);
        check("tmo_wb_valid", 32'(wb_valid_o), 32'd1);
        check("tmo_wb_we", 32'(wb_WriteReg_o), 32'd0);
        check("tmo_req_low", 32'(mem_req_o), 32'd0);
        check("tmo_stall_low", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        check("tmo_err_pulse", 32'(err_o), 32'd0);
`endif

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            int kind;
            logic [4:0] rd;
            kind = $urandom_range(0, 2);
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run_op(kind, 3'($urandom), $urandom, $urandom, $urandom, $urandom, rd,
                   (kind == 1) ? 1'b1 : 1'($urandom), $urandom_range(0, 5), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
